// File: rtl/ams_pwm_dac_if.sv
// Bus bundle between a DAC config source and one PWM DAC channel.
// The master drives the config word. The slave (DAC) drives the PWM output and the frame strobe.
interface ams_pwm_dac_if #(
  parameter int CCW = 24
);
  logic [CCW-1:0] cfg_i;
  logic           pwm_o;
  logic           frame_o;

  modport master (output cfg_i, input pwm_o, frame_o);
  modport slave  (input cfg_i, output pwm_o, frame_o);
endinterface

// File: rtl/ams_pwm_dac.sv
// Dithered PWM DAC: 2**DW-cycle periods, SW-period frames; pwm_o lags period start by 1 cycle.
// No backpressure; cfg_i is shadowed once per frame so mid-frame changes never glitch the output.
module ams_pwm_dac #(
  parameter int DW  = 8,
  parameter int SW  = 16,
  parameter int CCW = DW + SW
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  ams_pwm_dac_if.slave     bus
);
  localparam int SEQW = (SW > 1) ? $clog2(SW) : 1;

  logic [DW-1:0]   cnt_q;
  logic [SEQW-1:0] seq_q;
  logic [CCW-1:0]  cfg_q;
  logic [DW:0]     duty_q;
  logic            pwm_q;
  logic            frame_q;

  logic            wrap;
  logic            frame_end;
  logic [SEQW-1:0] seq_nxt;
  logic [CCW-1:0]  cfg_src;
  logic [SW-1:0]   dither;
  logic [DW:0]     duty_d;
  logic            pwm_d;

  always_comb begin
    wrap      = (cnt_q == {DW{1'b1}});
    frame_end = wrap && (seq_q == SEQW'(SW - 1));
    seq_nxt   = seq_q + SEQW'(1);
    // The word latched at frame end must already govern period 0 of the new frame.
    cfg_src   = frame_end ? bus.cfg_i : cfg_q;
    dither    = cfg_src[SW-1:0];
    // Carry kept so duty 2**DW yields a fully-high period.
    duty_d    = {1'b0, cfg_src[CCW-1:SW]} + {{DW{1'b0}}, dither[seq_nxt]};
    pwm_d     = ({1'b0, cnt_q} < duty_q);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q   <= '0;
      seq_q   <= '0;
      cfg_q   <= '0;
      duty_q  <= '0;
      pwm_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_q + DW'(1);
      pwm_q   <= pwm_d;
      frame_q <= frame_end;
      if (wrap) begin
        seq_q  <= seq_nxt;
        duty_q <= duty_d;
      end
      if (frame_end) begin
        cfg_q <= bus.cfg_i;
      end
    end
  end

  assign bus.pwm_o   = pwm_q;
  assign bus.frame_o = frame_q;
endmodule

// File: doc/ams_pwm_dac.md
Name: ams_pwm_dac

Overview:
PWM DAC generator: the consumer side of the 24-bit slow-DAC configuration words written over the system bus by the analog mixed-signal register block (its dac_a_o…dac_d_o outputs).
- Each word holds an 8-bit base duty and a 16-bit dither sequence.
- The block outputs a 1-bit PWM stream whose high time per 256-cycle period is the base duty plus the sequence bit for that period.
- One instance per slow DAC channel; output drives the external RC filter pin.

Parameters:
DW, 8, duty/counter width; PWM period = 2**DW cycles
SW, 16, dither sequence length in periods; power of two; frame = SW*2**DW cycles
CCW, DW+SW (24), configuration word width

Ports:
clk_i  in  1  clock (same domain as cfg_i source)
rstn_i  in  1  asynchronous active-low reset
cfg_i  in  CCW  config word: [CCW-1:SW] base duty, [SW-1:0] dither bits
pwm_o  out  1  PWM output, registered
frame_o  out  1  one-cycle strobe: cfg_i sampled into shadow register this cycle

Behaviour:
- Reset (async assert, sync release): cnt=0, seq=0, cfg_r=0, duty_eff=0, pwm_o=0, frame_o=0.
  - First frame after reset uses cfg_r=0, so pwm_o stays low for the first SW*2**DW cycles.
- Period counter cnt (DW bits):
  - Increments every cycle; wraps 2**DW-1 -> 0.
  - wrap = (cnt == 2**DW-1).
- Sequence index seq (log2(SW) bits):
  - Increments on wrap; wraps SW-1 -> 0.
  - frame_end = wrap && seq == SW-1.
- Shadow register:
  - On frame_end, cfg_r <= cfg_i and frame_o <= 1; frame_o = 0 in all other cycles.
  - cfg_i changes at any other time have no effect until the next frame_end. This is required for glitch-free updates.
- Effective duty duty_eff (DW+1 bits, unsigned), loaded on every wrap for the next period:
  - Index n = (seq+1) mod SW.
  - Source word c = cfg_i if frame_end, else cfg_r. The new word applies from period 0 of the new frame.
  - duty_eff <= {1'b0, c[CCW-1:SW]} + c[n].
  - Range 0..2**DW. The carry bit must be kept, no saturation.
- Output: pwm_o <= ({1'b0,cnt} < duty_eff), evaluated on registered values.
  - pwm_o lags the period start by exactly 1 cycle.
  - High time per period = duty_eff cycles exactly.
  - duty_eff = 0 -> low for the whole period.
  - duty_eff = 2**DW -> high for the whole period, contiguous across periods (no 1-cycle gap).
- Period 0 of every frame uses dither bit 0 (LSB), period k uses bit k.
  - Average high cycles per frame = SW*duty + popcount(dither).
- Async reset mid-period: pwm_o drops to 0 immediately; on release all counting restarts from cnt=0, seq=0.
- No combinational path from cfg_i to any output.

Test Plan:
1. Reset, cfg_i=0 -> pwm_o never high; frame_o pulses once every 4096 cycles, first at cycle 4095 after release.
2. cfg_i=24'h800000 held -> after the first frame_o, every 256-cycle period has exactly 128 contiguous high cycles, starting 1 cycle after cnt=0.
3. cfg_i=24'h805555 -> per frame, periods 0,2,4,…,14 have 129 high cycles and odd periods have 128; total 2056 per 4096 cycles.
4. cfg_i=24'hFFFFFF -> duty_eff=256 every period; pwm_o continuously high across period and frame boundaries. cfg_i=24'hFF0000 -> 255 high and 1 low per period.
5. Change cfg_i from 24'h400000 to 24'hC00000 mid-frame -> high time stays 64 until the next frame_o; the period immediately after frame_o has 192.
6. Assert rstn_i low at cnt=100 of a high phase -> pwm_o=0 within the same cycle (async). After release, pwm_o low for 4096 cycles, then resumes per cfg_i.
